lfsr_seq_ctrl: RTL
==================

// Module: lfsr_seq_ctrl
// PURPOSE
//  Sequencer for the degree-11 LFSR generator: accepts a seed/length request, seeds the LFSR,
//  steps it once per collected bit, and packs the serial LFSR output into OUT_W-bit words.
//  Sits between a requester (valid/ready) and the LFSR's WrEn/SeedWr/Seed/LFSR_DO pins.
//  Owns all LFSR enables, applies output backpressure by freezing the LFSR and supports abort.
// PARAMETERS
//  DEGREE  11  LFSR width; also the width of Seed_DI and LfsrSeed_DO
//  OUT_W   8   packed output word width (>=2)
//  CNT_W   16  width of the bit-count request field
// PORTS
//  Clk_CI        in   1       single clock; every flop rises on this edge
//  Rst_RI        in   1       one clock; reset is asynchronous and active-high
//  ReqValid_SI   in   1       request valid
//  ReqReady_SO   out  1       request ready (=IDLE && !Abort_SI)
//  Seed_DI       in   DEGREE  seed captured on request handshake
//  NumBits_DI    in   CNT_W   number of LFSR bits to produce, captured on handshake
//  Abort_SI      in   1       cancel current job
//  LfsrWrEn_SO   out  1       LFSR WrEn_SI (register-file and output-register enable)
//  LfsrSeedWr_SO out  1       LFSR SeedWr_DI
//  LfsrSeed_DO   out  DEGREE  LFSR Seed_DI (captured seed, held stable for the whole job)
//  LfsrBit_DI    in   1       LFSR_DO (registered LFSR output)
//  OutValid_SO   out  1       output word valid
//  OutReady_SI   in   1       output word ready
//  OutWord_DO    out  OUT_W   packed word; first generated bit in bit 0
//  OutLast_SO    out  1       word is the final one of the job
//  Busy_SO       out  1       state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except ReqReady_SO=1; seed reg, counters, word regs cleared.
//  States: IDLE -> LOAD -> PRIME -> RUN -> DRAIN -> IDLE.
//  IDLE: ReqValid&&ReqReady captures Seed/NumBits. NumBits==0 -> stay IDLE, no LFSR activity, no output.
//  LOAD (1 cyc): LfsrWrEn=1, LfsrSeedWr=1 -> LFSR loads seed; LFSR_DO gets a don't-care bit.
//  PRIME (1 cyc): LfsrWrEn=1, SeedWr=0 -> LFSR_DO holds bit0 from next cycle. LfsrBit_DI ignored.
//  RUN: LfsrWrEn=1 means LfsrBit_DI is sampled into packing reg at bit index cnt%OUT_W
//    and the LFSR advances in the same cycle. Otherwise both freeze; the LFSR holds because WrEn=0.
//  Word completes when OUT_W bits are packed or the final (NumBits-th) bit is packed.
//    Unused upper bits of a partial word are 0.
//  Stall: LfsrWrEn=0 in RUN iff the current sample would complete a word
//    AND OutValid_SO=1 AND !OutReady_SI. Output reg may load in the same cycle it is drained.
//  Completed word: loads OutWord_DO next edge, OutValid=1, OutLast=1 iff it holds the final bit.
//    Held stable until OutValid&&OutReady.
//  After the final bit is sampled: -> DRAIN, LfsrWrEn=0. DRAIN -> IDLE on the OutLast handshake.
//  Latency: request handshake -> first OutValid = 2 + OUT_W + 1 cycles, unstalled.
//  Sustained rate: one bit per cycle, unstalled.
//  Abort (any non-IDLE state): next edge -> IDLE. OutValid/OutLast cleared, partial word dropped,
//    LfsrWrEn/SeedWr 0 that cycle. Abort in IDLE blocks acceptance only.
//  Async reset mid-job behaves as abort plus full clear. The LFSR's own reset is driven externally.
//  Bit counter is CNT_W wide and never wraps. NumBits=2^CNT_W-1 is legal.
// TESTING
//  1 Seed=0, NumBits=20, OUT_W=8, OutReady=1 -> words 0x00,0x00,0x00(OutLast, 4 valid bits). Returns to IDLE.
//  2 Seed=0x001, NumBits=16 -> 2 words match a C model of the x^11+x^10+x^8+x^7+x^5+x^4+x^3+x+1 LFSR.
//    First OutValid occurs 11 cycles after the handshake.
//  3 Seed=0x5A5, NumBits=24, OutReady low for 10 cycles after the first word.
//    -> LfsrWrEn drops at the 16th bit, no bit lost or duplicated, 3 words match the model.
//  4 NumBits=8, OutReady=1 -> 1 word with OutLast=1.
//    NumBits=0 -> no LfsrWrEn pulse, no OutValid, ReqReady stays 1.
//  5 Abort asserted in RUN after 5 bits -> next cycle IDLE, OutValid=0, LfsrWrEn=0.
//    A new request (Seed=0x001) then reproduces test 2's words.
//  6 Rst_RI pulsed mid-DRAIN with OutValid=1 -> outputs clear asynchronously, ReqReady_SO=1 after release.

Source files
------------

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for an external degree-11 LFSR: seeds it, steps it once per collected bit
// and packs the serial output into OUT_W-bit words with valid/ready backpressure and abort.
module lfsr_seq_ctrl #(
  parameter int unsigned DEGREE = 11,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk_CI,
  input  logic              Rst_RI,
  input  logic              ReqValid_SI,
  output logic              ReqReady_SO,
  input  logic [DEGREE-1:0] Seed_DI,
  input  logic [CNT_W-1:0]  NumBits_DI,
  input  logic              Abort_SI,
  output logic              LfsrWrEn_SO,
  output logic              LfsrSeedWr_SO,
  output logic [DEGREE-1:0] LfsrSeed_DO,
  input  logic              LfsrBit_DI,
  output logic              OutValid_SO,
  input  logic              OutReady_SI,
  output logic [OUT_W-1:0]  OutWord_DO,
  output logic              OutLast_SO,
  output logic              Busy_SO
);

  localparam int unsigned IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PRIME = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DEGREE-1:0]  seed_q, seed_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   pack_q, pack_d;
  logic [OUT_W-1:0]   word_q, word_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;

  logic               wr_en;
  logic               seed_wr;
  logic               last_bit;
  logic               word_done;
  logic [OUT_W-1:0]   sample_word;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q <= S_IDLE;
      seed_q  <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      pack_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pack_q  <= pack_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pack_d      = pack_q;
    word_d      = word_q;
    valid_d     = valid_q;
    last_d      = last_q;
    wr_en       = 1'b0;
    seed_wr     = 1'b0;
    sample_word = pack_q;
    last_bit    = (cnt_q == (num_q - CNT_W'(1)));
    word_done   = (idx_q == IDX_W'(OUT_W - 1)) || last_bit;

    // Output register drains independently; a new word may reload it below.
    if (valid_q && OutReady_SI) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (ReqValid_SI && !Abort_SI) begin
          seed_d = Seed_DI;
          num_d  = NumBits_DI;
          cnt_d  = '0;
          idx_d  = '0;
          pack_d = '0;
          if (NumBits_DI != '0) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wr_en   = 1'b1;
        seed_wr = 1'b1;
        state_d = S_PRIME;
      end
      S_PRIME: begin
        wr_en   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Freeze the LFSR only when this bit would need an output slot that is still occupied.
        wr_en = !(word_done && valid_q && !OutReady_SI);
        if (wr_en) begin
          sample_word[idx_q] = LfsrBit_DI;
          cnt_d = cnt_q + CNT_W'(1);
          if (word_done) begin
            word_d  = sample_word;
            valid_d = 1'b1;
            last_d  = last_bit;
            pack_d  = '0;
            idx_d   = '0;
          end else begin
            pack_d = sample_word;
            idx_d  = idx_q + IDX_W'(1);
          end
          if (last_bit) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (valid_q && last_q && OutReady_SI) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops everything in flight, including a pending output word.
    if (Abort_SI && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      wr_en   = 1'b0;
      seed_wr = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      pack_d  = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  assign ReqReady_SO   = (state_q == S_IDLE) && !Abort_SI;
  assign Busy_SO       = (state_q != S_IDLE);
  assign LfsrWrEn_SO   = wr_en;
  assign LfsrSeedWr_SO = seed_wr;
  assign LfsrSeed_DO   = seed_q;
  assign OutValid_SO   = valid_q;
  assign OutWord_DO    = word_q;
  assign OutLast_SO    = last_q;

endmodule
